progmem_loader: RTL and testbench

Parametrised, loadable program memory for the RISC core: a synchronous-read instruction ROM/RAM with a fetch request/valid port and a sequential word-loader port.
- Replaces the fixed-content combinational program store; the core fetches through it, and a host/boot engine streams programs in after reset.
- Loading and fetching are mutually exclusive, arbitrated by an internal state machine; `busy` tells the core to stall.

---
 rtl/progmem_loader.sv | 103 ++++++++++
 tb/tb_progmem_loader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/progmem_loader.sv
// Loadable program memory: synchronous-read fetch port plus a sequential word loader.
// Optional per-word even parity is enabled by defining PROGMEM_PARITY_EN.
module progmem_loader #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] instr,
  output logic              fetch_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              busy,
  input  logic              load_par_flip,
  output logic              instr_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] wptr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              accept;
  logic              fetch_go;
  logic              last_word;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    fetch_go  = 1'b0;
    last_word = load_last || (wptr == '1);
    case (state)
      IDLE: begin
        // A load request takes priority; the concurrent fetch is dropped.
        if (load_start) state_nxt = LOAD;
        else            fetch_go  = fetch_req;
      end
      LOAD: begin
        accept = load_valid;
        if (load_valid && last_word) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      wptr  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && load_start) wptr <= '0;
      else if (accept)                 wptr <= wptr + 1'b1;
    end
  end

  assign load_ready = (state == LOAD);
  assign load_done  = (state == DONE);
  assign busy       = (state != IDLE);

  // Storage is deliberately unreset so words survive a mid-load reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr       <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_go;
      if (fetch_go) instr <= mem[fetch_addr];
    end
  end

`ifdef PROGMEM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (accept) par_mem[wptr] <= (^load_data) ^ load_par_flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instr_err <= 1'b0;
    else        instr_err <= fetch_go && (par_mem[fetch_addr] != (^mem[fetch_addr]));
  end
`else
  logic unused_par_flip;
  assign unused_par_flip = load_par_flip;
  assign instr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_progmem_loader.sv
// Directed bench for progmem_loader: load/fetch sequencing, gaps, full-depth load,
// load/fetch collision, mid-load reset and the optional parity hook.
module tb_progmem_loader;

  logic       clk;
  logic       rst_n;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic [7:0] instr;
  logic       fetch_valid;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic       load_done;
  logic       busy;
  logic       load_par_flip;
  logic       instr_err;

  int checks = 0;
  int errors = 0;

  progmem_loader #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_req     (fetch_req),
    .fetch_addr    (fetch_addr),
    .instr         (instr),
    .fetch_valid   (fetch_valid),
    .load_start    (load_start),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .load_done     (load_done),
    .busy          (busy),
    .load_par_flip (load_par_flip),
    .instr_err     (instr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] words [4];
    words[0] = 8'h81; words[1] = 8'h94; words[2] = 8'h04; words[3] = 8'hC0;

    rst_n = 1'b0; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0; load_par_flip = 1'b0;
    tick(); tick();
    chk("rst_instr", instr, 8'h00);
    chk("rst_fetch_valid", fetch_valid, 1'b0);
    chk("rst_load_ready", load_ready, 1'b0);
    chk("rst_load_done", load_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_instr_err", instr_err, 1'b0);
    rst_n = 1'b1;
    tick();

    // Basic 4-word load
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("ld4_busy", busy, 1'b1);
    chk("ld4_ready", load_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1; load_data = words[i]; load_last = (i == 3);
      tick();
      if (i < 3) chk("ld4_no_done_early", load_done, 1'b0);
    end
    load_valid = 1'b0; load_last = 1'b0;
    chk("ld4_done", load_done, 1'b1);
    chk("ld4_done_ready", load_ready, 1'b0);
    tick();
    chk("ld4_done_pulse", load_done, 1'b0);
    chk("ld4_idle_busy", busy, 1'b0);
    fetch_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_addr = 8'(i);
      tick();
      chk("ld4_fetch_valid", fetch_valid, 1'b1);
      chk("ld4_fetch_instr", instr, words[i]);
      chk("ld4_fetch_err", instr_err, 1'b0);
    end
    fetch_req = 1'b0;
    tick();
    chk("hold_fetch_valid", fetch_valid, 1'b0);
    chk("hold_instr", instr, 8'hC0);

    // Load with gaps: valid pattern 1,0,0,1; gap data must not be written
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'hA1; tick();
    load_valid = 1'b0; load_data = 8'hEE; fetch_req = 1'b1; fetch_addr = 8'h00; tick();
    chk("gap_fetch_in_load", fetch_valid, 1'b0);
    chk("gap_instr_held", instr, 8'hC0);
    fetch_req = 1'b0; tick();
    load_valid = 1'b1; load_data = 8'hA2; tick();
    chk("gap_wptr", dut.wptr, 8'd2);
    chk("gap_still_busy", busy, 1'b1);
    chk("gap_no_done", load_done, 1'b0);
    load_data = 8'hA3; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("gap_done", load_done, 1'b1);
    tick();
    fetch_req = 1'b1;
    fetch_addr = 8'd0; tick(); chk("gap_addr0", instr, 8'hA1);
    fetch_addr = 8'd1; tick(); chk("gap_addr1", instr, 8'hA2);
    fetch_addr = 8'd2; tick(); chk("gap_addr2", instr, 8'hA3);
    fetch_addr = 8'd3; tick(); chk("gap_addr3_old", instr, 8'hC0);
    fetch_req = 1'b0;
    tick();

    // Full-depth load without load_last
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      load_valid = 1'b1; load_data = 8'(i);
      tick();
      if (i == 254) chk("full_no_done_254", load_done, 1'b0);
    end
    chk("full_done", load_done, 1'b1);
    load_data = 8'h77;
    tick();
    load_valid = 1'b0;
    chk("full_idle", busy, 1'b0);
    fetch_req = 1'b1;
    fetch_addr = 8'd0;   tick(); chk("full_addr0", instr, 8'h00);
    fetch_addr = 8'd255; tick(); chk("full_addr255", instr, 8'hFF);
    fetch_addr = 8'd1;   tick(); chk("full_addr1", instr, 8'h01);

    // Collision: load_start with fetch_req in IDLE
    fetch_addr = 8'd5; load_start = 1'b1;
    tick();
    fetch_req = 1'b0; load_start = 1'b0;
    chk("coll_fetch_valid", fetch_valid, 1'b0);
    chk("coll_busy", busy, 1'b1);
    chk("coll_instr_held", instr, 8'h01);

    // Reset mid-load after 2 of 4 words
    load_valid = 1'b1; load_data = 8'h33; tick();
    load_data = 8'h44; tick();
    load_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", load_ready, 1'b0);
    chk("mid_rst_done", load_done, 1'b0);
    chk("mid_rst_instr", instr, 8'h00);
    chk("mid_rst_fetch_valid", fetch_valid, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_no_done", load_done, 1'b0);
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h11; tick();
    load_data = 8'h22; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    chk("reload_done", load_done, 1'b1);
    tick();
    fetch_req = 1'b1;
    fetch_addr = 8'd1; tick(); chk("reload_addr1", instr, 8'h22);
    fetch_addr = 8'd0; tick(); chk("reload_addr0", instr, 8'h11);
    fetch_req = 1'b0;
    tick();

    // Parity hook: flipped parity at addr 0, clean at addr 1
    load_start = 1'b1; tick(); load_start = 1'b0;
    load_valid = 1'b1; load_data = 8'h5A; load_par_flip = 1'b1; tick();
    load_par_flip = 1'b0; load_last = 1'b1; tick();
    load_valid = 1'b0; load_last = 1'b0;
    tick();
    fetch_req = 1'b1;
    fetch_addr = 8'd0; tick();
    chk("par_addr0_instr", instr, 8'h5A);
`ifdef PROGMEM_PARITY_EN
    chk("par_addr0_err", instr_err, 1'b1);
`else
    chk("par_addr0_err_off", instr_err, 1'b0);
`endif
    fetch_addr = 8'd1; tick();
    chk("par_addr1_instr", instr, 8'h5A);
    chk("par_addr1_err", instr_err, 1'b0);
    fetch_req = 1'b0; tick();
    chk("par_err_clear", instr_err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
